// File: rtl/udatapath_pkg.sv
// Shared definitions for the pipelined micro-datapath: ALU/shift codes,
// flag bit positions and a constant-evaluable ceil(log2) helper.
package udatapath_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluNot   = 4'd5,
        AluPassA = 4'd6,
        AluPassB = 4'd7,
        AluInc   = 4'd8,
        AluDec   = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ShNone = 2'd0,
        ShShl1 = 2'd1,
        ShShr1 = 2'd2,
        ShRor1 = 2'd3
    } shift_op_e;

    // Bit positions inside the internal (active-high) flag vector
    localparam int unsigned FlagZ    = 0;
    localparam int unsigned FlagN    = 1;
    localparam int unsigned FlagC    = 2;
    localparam int unsigned FlagV    = 3;
    localparam int unsigned NumFlags = 4;

    // Smallest r with 2**r >= value
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cc_alu_shift.sv
// Combinational ALU followed by a single-bit shifter, producing the
// result and active-high C/V/N/Z flags.
module cc_alu_shift
    import udatapath_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = 8
) (
    input  logic [DATAWIDTH_BUS-1:0] a_i,
    input  logic [DATAWIDTH_BUS-1:0] b_i,
    input  logic [3:0]               alu_op_i,
    input  logic [1:0]               shift_op_i,
    output logic [DATAWIDTH_BUS-1:0] result_o,
    output logic [NumFlags-1:0]      flags_o
);

    localparam int unsigned Msb = DATAWIDTH_BUS - 1;

    logic [DATAWIDTH_BUS-1:0] add_b;
    logic                     add_cin;
    logic                     arith;
    logic [DATAWIDTH_BUS:0]   sum;
    logic [DATAWIDTH_BUS-1:0] alu_res;
    logic                     carry;
    logic                     ovf;

    // ALU select, shared adder (SUB/DEC as A + ~B + 1), then post-shift and flags
    always_comb begin
        add_b    = b_i;
        add_cin  = 1'b0;
        arith    = 1'b0;
        alu_res  = a_i;
        case (alu_op_i)
            AluAdd:   arith = 1'b1;
            AluSub:   begin add_b = ~b_i; add_cin = 1'b1; arith = 1'b1; end
            AluAnd:   alu_res = a_i & b_i;
            AluOr:    alu_res = a_i | b_i;
            AluXor:   alu_res = a_i ^ b_i;
            AluNot:   alu_res = ~a_i;
            AluPassA: alu_res = a_i;
            AluPassB: alu_res = b_i;
            AluInc:   begin add_b = '0; add_cin = 1'b1; arith = 1'b1; end
            AluDec:   begin
                add_b   = ~DATAWIDTH_BUS'(1);
                add_cin = 1'b1;
                arith   = 1'b1;
            end
            default:  alu_res = a_i;
        endcase

        sum = {1'b0, a_i} + {1'b0, add_b} + {{DATAWIDTH_BUS{1'b0}}, add_cin};
        if (arith) begin
            alu_res = sum[Msb:0];
        end
        carry = arith & sum[DATAWIDTH_BUS];
        ovf   = arith & (a_i[Msb] == add_b[Msb]) & (sum[Msb] != a_i[Msb]);

        case (shift_op_i)
            ShShl1:  result_o = {alu_res[Msb-1:0], 1'b0};
            ShShr1:  result_o = {1'b0, alu_res[Msb:1]};
            ShRor1:  result_o = {alu_res[0], alu_res[Msb:1]};
            default: result_o = alu_res;
        endcase

        flags_o        = '0;
        flags_o[FlagC] = carry;
        flags_o[FlagV] = ovf;
        flags_o[FlagN] = result_o[Msb];
        flags_o[FlagZ] = (result_o == '0);
    end

endmodule

// File: rtl/udatapath_pipe.sv
// Two-stage pipelined micro-datapath: general register file plus read-only
// constants, operand read with full forwarding (S1), ALU+shift into S2, and
// writeback on retire. Flags leave the block active-low.
module udatapath_pipe
    import udatapath_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS       = 8,
    parameter int unsigned NUM_REG_GENERAL     = 4,
    parameter int unsigned NUM_REG_FIXED       = 2,
    parameter logic [NUM_REG_FIXED*DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT = {8'h0F, 8'h09},
    parameter int unsigned DISPLAY_INDEX       = NUM_REG_GENERAL - 1,
    parameter int unsigned DATAWIDTH_SELECTION = clog2(NUM_REG_GENERAL + NUM_REG_FIXED + 1)
) (
    input  logic                           uDataPathPipe_CLOCK_50,
    input  logic                           uDataPathPipe_Reset_InLow,
    input  logic                           uDataPathPipe_OpValid_InHigh,
    output logic                           uDataPathPipe_OpReady_OutHigh,
    input  logic                           uDataPathPipe_Stall_InHigh,
    input  logic [DATAWIDTH_SELECTION-1:0] uDataPathPipe_SelA_In,
    input  logic [DATAWIDTH_SELECTION-1:0] uDataPathPipe_SelB_In,
    input  logic [DATAWIDTH_SELECTION-1:0] uDataPathPipe_SelWrite_In,
    input  logic [3:0]                     uDataPathPipe_ALUSelection_In,
    input  logic [1:0]                     uDataPathPipe_ShiftSelection_In,
    output logic                           uDataPathPipe_ResultValid_OutHigh,
    output logic [DATAWIDTH_BUS-1:0]       uDataPathPipe_Result_Out,
    output logic [DATAWIDTH_BUS-1:0]       uDataPathPipe_DataBUSDisplay_Out,
    output logic                           uDataPathPipe_Overflow_OutLow,
    output logic                           uDataPathPipe_Carry_OutLow,
    output logic                           uDataPathPipe_Negative_OutLow,
    output logic                           uDataPathPipe_Zero_OutLow
);

    localparam int unsigned W  = DATAWIDTH_BUS;
    localparam int unsigned SW = DATAWIDTH_SELECTION;
    localparam int unsigned NG = NUM_REG_GENERAL;
    localparam int unsigned NF = NUM_REG_FIXED;

    logic stall;
    assign stall = uDataPathPipe_Stall_InHigh;

    // Architectural and pipeline state
    logic [NG-1:0][W-1:0]  regs_q, regs_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [W-1:0]          s1_a_q, s1_a_d;
    logic [W-1:0]          s1_b_q, s1_b_d;
    logic [3:0]            s1_alu_q, s1_alu_d;
    logic [1:0]            s1_shift_q, s1_shift_d;
    logic [SW-1:0]         s1_dest_q, s1_dest_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [W-1:0]          s2_result_q, s2_result_d;
    logic [NumFlags-1:0]   s2_flags_q, s2_flags_d;
    logic [SW-1:0]         s2_dest_q, s2_dest_d;

    // S1 execution result, used both for forwarding and for S2 capture
    logic [W-1:0]          ex_result;
    logic [NumFlags-1:0]   ex_flags;

    logic [1:0][SW-1:0]    rd_sel;
    logic [1:0][W-1:0]     rd_data;
    logic                  s1_fwd_ok;
    logic                  s2_fwd_ok;

    cc_alu_shift #(
        .DATAWIDTH_BUS (W)
    ) u_alu_shift (
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .alu_op_i   (s1_alu_q),
        .shift_op_i (s1_shift_q),
        .result_o   (ex_result),
        .flags_o    (ex_flags)
    );

    assign rd_sel[0] = uDataPathPipe_SelA_In;
    assign rd_sel[1] = uDataPathPipe_SelB_In;

    // Only ops that actually write a general register may be forwarded
    assign s1_fwd_ok = s1_valid_q && (s1_dest_q < SW'(NG));
    assign s2_fwd_ok = s2_valid_q && (s2_dest_q < SW'(NG));

    // Operand read: later assignments win, giving S1 > S2 > register file
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            for (int i = 0; i < int'(NG); i++) begin
                if (rd_sel[p] == SW'(i)) rd_data[p] = regs_q[i];
            end
            for (int i = 0; i < int'(NF); i++) begin
                if (rd_sel[p] == SW'(int'(NG) + i)) rd_data[p] = DATA_REGFIXED_INIT[i*W +: W];
            end
            if (s2_fwd_ok && (s2_dest_q == rd_sel[p])) rd_data[p] = s2_result_q;
            if (s1_fwd_ok && (s1_dest_q == rd_sel[p])) rd_data[p] = ex_result;
        end
    end

    // Next state: everything holds on stall; otherwise advance S1->S2->regfile
    always_comb begin
        regs_d      = regs_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_alu_d    = s1_alu_q;
        s1_shift_d  = s1_shift_q;
        s1_dest_d   = s1_dest_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_dest_d   = s2_dest_q;
        if (!stall) begin
            s1_valid_d = uDataPathPipe_OpValid_InHigh;
            s1_a_d     = rd_data[0];
            s1_b_d     = rd_data[1];
            s1_alu_d   = uDataPathPipe_ALUSelection_In;
            s1_shift_d = uDataPathPipe_ShiftSelection_In;
            s1_dest_d  = uDataPathPipe_SelWrite_In;

            s2_valid_d = s1_valid_q;
            s2_dest_d  = s1_dest_q;
            // Result and flags hold through bubbles
            if (s1_valid_q) begin
                s2_result_d = ex_result;
                s2_flags_d  = ex_flags;
            end

            if (s2_valid_q) begin
                for (int i = 0; i < int'(NG); i++) begin
                    if (s2_dest_q == SW'(i)) regs_d[i] = s2_result_q;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge uDataPathPipe_CLOCK_50 or negedge uDataPathPipe_Reset_InLow) begin
        if (!uDataPathPipe_Reset_InLow) begin
            regs_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_alu_q    <= '0;
            s1_shift_q  <= '0;
            s1_dest_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_dest_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_alu_q    <= s1_alu_d;
            s1_shift_q  <= s1_shift_d;
            s1_dest_q   <= s1_dest_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_dest_q   <= s2_dest_d;
        end
    end

    assign uDataPathPipe_OpReady_OutHigh     = ~stall;
    assign uDataPathPipe_ResultValid_OutHigh = s2_valid_q & ~stall;
    assign uDataPathPipe_Result_Out          = s2_result_q;
    assign uDataPathPipe_DataBUSDisplay_Out  = regs_q[DISPLAY_INDEX];
    assign uDataPathPipe_Overflow_OutLow     = ~s2_flags_q[FlagV];
    assign uDataPathPipe_Carry_OutLow        = ~s2_flags_q[FlagC];
    assign uDataPathPipe_Negative_OutLow     = ~s2_flags_q[FlagN];
    assign uDataPathPipe_Zero_OutLow         = ~s2_flags_q[FlagZ];

endmodule

// File: tb/tb_udatapath_pipe.sv
// Directed bench for udatapath_pipe with hand-computed expectations.
// obs_w packs {ResultValid, Result, OvfL, CarryL, NegL, ZeroL}.
module tb_udatapath_pipe;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic       stall;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic [2:0] sel_w;
    logic [3:0] alu_op;
    logic [1:0] sh_op;
    logic       res_valid;
    logic [7:0] result;
    logic [7:0] display;
    logic       ovf_n;
    logic       carry_n;
    logic       neg_n;
    logic       zero_n;

    logic [12:0] obs_w;
    logic [12:0] want;
    int checks;
    int errors;

    assign obs_w = {res_valid, result, ovf_n, carry_n, neg_n, zero_n};

    udatapath_pipe dut (
        .uDataPathPipe_CLOCK_50           (clk),
        .uDataPathPipe_Reset_InLow        (rst_n),
        .uDataPathPipe_OpValid_InHigh     (op_valid),
        .uDataPathPipe_OpReady_OutHigh    (op_ready),
        .uDataPathPipe_Stall_InHigh       (stall),
        .uDataPathPipe_SelA_In            (sel_a),
        .uDataPathPipe_SelB_In            (sel_b),
        .uDataPathPipe_SelWrite_In        (sel_w),
        .uDataPathPipe_ALUSelection_In    (alu_op),
        .uDataPathPipe_ShiftSelection_In  (sh_op),
        .uDataPathPipe_ResultValid_OutHigh(res_valid),
        .uDataPathPipe_Result_Out         (result),
        .uDataPathPipe_DataBUSDisplay_Out (display),
        .uDataPathPipe_Overflow_OutLow    (ovf_n),
        .uDataPathPipe_Carry_OutLow       (carry_n),
        .uDataPathPipe_Negative_OutLow    (neg_n),
        .uDataPathPipe_Zero_OutLow        (zero_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] w, input logic [3:0] op, input logic [1:0] s);
        op_valid = v;
        sel_a    = a;
        sel_b    = b;
        sel_w    = w;
        alu_op   = op;
        sh_op    = s;
    endtask

    task automatic bubble();
        drive(1'b0, 3'd0, 3'd0, 3'd7, 4'd0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        bubble();
        tick();
        tick();
        want = {1'b1, 8'h00, 4'hF} & 13'h0FFF;
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", obs_w, want);
        end
        checks++;
        if ({op_ready, display} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_ready_display: got %h want %h", {op_ready, display}, 9'h100);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_add();
        drive(1'b1, 3'd4, 3'd5, 3'd0, 4'd0, 2'd0);  // R0 = 0x09 + 0x0F
        tick();
        bubble();
        tick();
        want = {1'b1, 8'h18, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL add_fixed: got %h want %h", obs_w, want);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pulse_width: got %b want 0", res_valid);
        end
        drive(1'b1, 3'd0, 3'd6, 3'd7, 4'd6, 2'd0);  // read R0 from the register file
        tick();
        bubble();
        tick();
        want = {1'b1, 8'h18, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL add_writeback_r0: got %h want %h", obs_w, want);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd6, 3'd0, 3'd0, 4'd5, 2'd0);  // R0 = NOT 0 = 0xFF
        tick();
        drive(1'b1, 3'd0, 3'd0, 3'd1, 4'd8, 2'd0);  // R1 = INC R0 (S1 forward)
        tick();
        want = {1'b1, 8'hFF, 4'hD};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL b2b_not: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd1, 3'd0, 3'd7, 4'd0, 2'd0);  // R1 (S1) + R0 (S2), no write
        tick();
        want = {1'b1, 8'h00, 4'hA};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL b2b_inc_wrap: got %h want %h", obs_w, want);
        end
        bubble();
        tick();
        want = {1'b1, 8'hFF, 4'hD};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL b2b_fwd_add: got %h want %h", obs_w, want);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got %b want 0", res_valid);
        end
    endtask

    task automatic test_sub_overflow();
        drive(1'b1, 3'd4, 3'd5, 3'd2, 4'd1, 2'd0);  // R2 = 0x09 - 0x0F
        tick();
        drive(1'b1, 3'd6, 3'd0, 3'd1, 4'd5, 2'd2);  // R1 = (NOT 0) >> 1 = 0x7F
        tick();
        want = {1'b1, 8'hFA, 4'hD};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL sub_borrow: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd6, 3'd0, 3'd0, 4'd8, 2'd0);  // R0 = INC 0 = 0x01
        tick();
        want = {1'b1, 8'h7F, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL not_shr: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd1, 3'd0, 3'd7, 4'd0, 2'd0);  // 0x7F + 0x01
        tick();
        want = {1'b1, 8'h01, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL inc_zero: got %h want %h", obs_w, want);
        end
        bubble();
        tick();
        want = {1'b1, 8'h80, 4'h5};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL add_overflow: got %h want %h", obs_w, want);
        end
        tick();
    endtask

    task automatic test_shifts();
        drive(1'b1, 3'd1, 3'd0, 3'd2, 4'd0, 2'd0);  // R2 = 0x7F + 0x01 = 0x80
        tick();
        drive(1'b1, 3'd2, 3'd0, 3'd2, 4'd8, 2'd0);  // R2 = 0x81
        tick();
        want = {1'b1, 8'h80, 4'h5};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL shift_setup_add: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd2, 3'd0, 3'd7, 4'd6, 2'd1);  // SHL1, R2 via S1 over S2
        tick();
        want = {1'b1, 8'h81, 4'hD};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL shift_setup_inc: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd2, 3'd0, 3'd7, 4'd6, 2'd2);  // SHR1, R2 via S2
        tick();
        want = {1'b1, 8'h02, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL shl1: got %h want %h", obs_w, want);
        end
        drive(1'b1, 3'd2, 3'd0, 3'd7, 4'd6, 2'd3);  // ROR1, R2 from register file
        tick();
        want = {1'b1, 8'h40, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL shr1: got %h want %h", obs_w, want);
        end
        bubble();
        tick();
        want = {1'b1, 8'hC0, 4'hD};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL ror1: got %h want %h", obs_w, want);
        end
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 3'd4, 3'd0, 3'd3, 4'd6, 2'd0);  // R3 = 0x09
        tick();
        drive(1'b1, 3'd5, 3'd0, 3'd3, 4'd6, 2'd0);  // R3 = 0x0F
        tick();
        drive(1'b1, 3'd3, 3'd0, 3'd7, 4'd6, 2'd0);  // read R3: newest writer wins
        tick();
        bubble();
        tick();
        want = {1'b1, 8'h0F, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL fwd_priority: got %h want %h", obs_w, want);
        end
        checks++;
        if (display !== 8'h0F) begin
            errors++;
            $display("FAIL display_r3: got %h want 0f", display);
        end
        drive(1'b1, 3'd4, 3'd5, 3'd3, 4'd0, 2'd0);  // R3 = 0x18, sits in S1
        tick();
        stall = 1'b1;
        drive(1'b1, 3'd5, 3'd0, 3'd3, 4'd6, 2'd0);  // must not be accepted
        #1;
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: got %b want 0", op_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({res_valid, display} !== {1'b0, 8'h0F}) begin
                errors++;
                $display("FAIL stall_hold: got %h want 00f", {res_valid, display});
            end
        end
        stall = 1'b0;
        bubble();
        tick();
        want = {1'b1, 8'h18, 4'hF};
        checks++;
        if (obs_w !== want || display !== 8'h0F) begin
            errors++;
            $display("FAIL stall_release: got %h/%h want %h/0f", obs_w, display, want);
        end
        tick();
        checks++;
        if ({res_valid, display} !== {1'b0, 8'h18}) begin
            errors++;
            $display("FAIL stall_writeback: got %h want 018", {res_valid, display});
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_retire: got %b want 0", res_valid);
        end
    endtask

    task automatic test_fixed_write();
        drive(1'b1, 3'd6, 3'd0, 3'd4, 4'd5, 2'd0);  // 0xFF aimed at fixed reg 0
        tick();
        drive(1'b1, 3'd4, 3'd0, 3'd7, 4'd6, 2'd0);  // no forwarding from fixed dest
        tick();
        bubble();
        tick();
        want = {1'b1, 8'h09, 4'hF};
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL fixed_no_fwd: got %h want %h", obs_w, want);
        end
        tick();
        drive(1'b1, 3'd4, 3'd0, 3'd7, 4'd6, 2'd0);
        tick();
        bubble();
        tick();
        checks++;
        if (obs_w !== want) begin
            errors++;
            $display("FAIL fixed_readonly: got %h want %h", obs_w, want);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 3'd5, 3'd0, 3'd3, 4'd6, 2'd0);  // R3 = 0x0F, in flight
        tick();
        bubble();
        #2;
        rst_n = 1'b0;
        #1;
        want = {1'b0, 8'h00, 4'hF};
        checks++;
        if (obs_w !== want || display !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %h/%h want %h/00", obs_w, display, want);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({res_valid, display} !== {1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_drop: got %h want 000", {res_valid, display});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed_add();
        test_back_to_back();
        test_sub_overflow();
        test_shifts();
        test_stall();
        test_fixed_write();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
